// File: rtl/bcd_xs3_seq.sv
// Multi-digit BCD to excess-3 converter: one shared 4-bit converter walks the
// word LSD-first, one digit per clock, behind valid/ready handshakes.

module bcd_xs3_digit (
  input  logic [3:0] i_bcd,
  output logic [3:0] o_xs3,
  output logic       o_err
);
  always_comb begin
    o_err = (i_bcd > 4'd9);
    o_xs3 = o_err ? 4'd0 : (i_bcd + 4'd3);
  end
endmodule

module bcd_xs3_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_xs3,
  output logic [DIGITS-1:0]   out_err_mask,
  output logic                out_err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [W-1:0]      r_shift, w_shift_nxt;
  logic [W-1:0]      r_xs3, w_xs3_nxt;
  logic [DIGITS-1:0] r_mask, w_mask_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [3:0]        w_dig_xs3;
  logic              w_dig_err;

  // The captured word shifts right each CONV cycle, so the current digit is always [3:0].
  bcd_xs3_digit u_conv (
    .i_bcd (r_shift[3:0]),
    .o_xs3 (w_dig_xs3),
    .o_err (w_dig_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_shift     <= '0;
      r_xs3       <= '0;
      r_mask      <= '0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_shift     <= w_shift_nxt;
      r_xs3       <= w_xs3_nxt;
      r_mask      <= w_mask_nxt;
      r_idx       <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_shift_nxt     = r_shift;
    w_xs3_nxt       = r_xs3;
    w_mask_nxt      = r_mask;
    w_idx_nxt       = r_idx;
    case (r_state)
      S_IDLE: begin
        w_in_ready_nxt = 1'b1;
        if (in_valid && r_in_ready) begin
          w_shift_nxt    = in_bcd;
          w_xs3_nxt      = '0;
          w_mask_nxt     = '0;
          w_idx_nxt      = '0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = S_CONV;
        end
      end
      S_CONV: begin
        w_xs3_nxt[{r_idx, 2'b00} +: 4] = w_dig_xs3;
        w_mask_nxt[r_idx]              = w_dig_err;
        w_shift_nxt                    = r_shift >> 4;
        if (r_idx == LAST_IDX) begin
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_xs3      = r_xs3;
  assign out_err_mask = r_mask;
  assign out_err      = |r_mask;
endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Scoreboard bench for bcd_xs3_seq (DIGITS=4): expectations queued at accept,
// checked by a monitor while out_valid is high, popped on the output handshake.

module tb_bcd_xs3_seq;
  localparam int DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_xs3;
  logic [3:0]  out_err_mask;
  logic        out_err;

  typedef struct {
    logic [15:0] xs3;
    logic [3:0]  mask;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   prev_vld = 0;

  bcd_xs3_seq #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xs3      (out_xs3),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples 2 time units after the falling edge, when stimulus is settled.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL ready_valid_excl: in_ready=%b out_valid=%b, required not both 1", in_ready, out_valid);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: out_xs3=%h with empty scoreboard", out_xs3);
        end else begin
          e = q[0];
          if (!prev_vld) begin
            checks++;
            if (cyc - e.acc != DIGITS + 1) begin
              errors++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - e.acc - 1, DIGITS);
            end
          end
          checks++;
          if (out_xs3 !== e.xs3 || out_err_mask !== e.mask || out_err !== (|e.mask)) begin
            errors++;
            $display("FAIL result: xs3=%h mask=%b err=%b, required xs3=%h mask=%b err=%b",
                     out_xs3, out_err_mask, out_err, e.xs3, e.mask, |e.mask);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_vld = out_valid;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [15:0] w, input logic [15:0] x, input logic [3:0] m,
                      input bit keep, output int acc);
    int n = 0;
    exp_t t;
    in_bcd   = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc    = cyc;
    t.xs3  = x;
    t.mask = m;
    t.acc  = cyc;
    q.push_back(t);
    @(posedge clk);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bcd = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_xs3, out_err_mask, out_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b xs3=%h mask=%b err=%b, required all 0",
               in_ready, out_valid, out_xs3, out_err_mask, out_err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: in_ready=%b, required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int a;
    out_ready = 1'b1;
    send(16'h1234, 16'h4567, 4'b0000, 1'b0, a);
    drain();
  endtask

  task automatic test_boundary();
    logic [15:0] ins [3] = '{16'h9050, 16'h0000, 16'h9999};
    logic [15:0] exs [3] = '{16'hC383, 16'h3333, 16'hCCCC};
    int a;
    for (int i = 0; i < 3; i++) begin
      send(ins[i], exs[i], 4'b0000, 1'b0, a);
      drain();
    end
  endtask

  task automatic test_invalid();
    int a;
    send(16'h12A4, 16'h4507, 4'b0010, 1'b0, a);
    drain();
    send(16'hFFFF, 16'h0000, 4'b1111, 1'b0, a);
    drain();
  endtask

  task automatic test_backpressure();
    int a;
    int n = 0;
    out_ready = 1'b0;
    send(16'h1234, 16'h4567, 4'b0000, 1'b0, a);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_xs3 !== 16'h4567) begin
        errors++;
        $display("FAIL backpressure_hold: vld=%b rdy=%b xs3=%h, required vld=1 rdy=0 xs3=4567",
                 out_valid, in_ready, out_xs3);
      end
      in_bcd   = 16'($urandom);
      in_valid = ~in_valid;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    send(16'h5678, 16'h89AB, 4'b0000, 1'b0, a);
    drain();
  endtask

  task automatic test_reset_mid();
    int a;
    send(16'h9999, 16'hCCCC, 4'b0000, 1'b0, a);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_xs3, out_err_mask, out_err} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b vld=%b xs3=%h mask=%b err=%b, required all 0",
               in_ready, out_valid, out_xs3, out_err_mask, out_err);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0807, 16'h3B3A, 4'b0000, 1'b0, a);
    drain();
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3;
    out_ready = 1'b1;
    send(16'h1234, 16'h4567, 4'b0000, 1'b1, a1);
    send(16'h5678, 16'h89AB, 4'b0000, 1'b1, a2);
    send(16'h9012, 16'hC345, 4'b0000, 1'b0, a3);
    checks++;
    if (a2 - a1 != DIGITS + 2 || a3 - a2 != DIGITS + 2) begin
      errors++;
      $display("FAIL issue_interval: got %0d and %0d, required %0d", a2 - a1, a3 - a2, DIGITS + 2);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
